// File: rtl/rename_walk.sv
// Rollback walker: reads ROB groups youngest-first, restores RAT mappings and
// returns the speculatively allocated pregs to the freelist.
module rename_walk #(
    parameter int WALK_WIDTH = 4,
    parameter int ROB_WIDTH  = 6,
    parameter int PREG_WIDTH = 7,
    parameter int VREG_WIDTH = 5,
    parameter int CNT_WIDTH  = ROB_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             walk_start,
    input  logic [ROB_WIDTH-1:0]             walk_tail,
    input  logic [CNT_WIDTH-1:0]             walk_num,
    output logic                             rd_valid,
    output logic [ROB_WIDTH-1:0]             rd_idx,
    output logic [WALK_WIDTH-1:0]            rd_mask,
    input  logic                             rd_ready,
    input  logic [WALK_WIDTH-1:0]            ent_we,
    input  logic [WALK_WIDTH*VREG_WIDTH-1:0] ent_vrd,
    input  logic [WALK_WIDTH*PREG_WIDTH-1:0] ent_prd,
    input  logic [WALK_WIDTH*PREG_WIDTH-1:0] ent_old_prd,
    output logic [WALK_WIDTH-1:0]            rat_we,
    output logic [WALK_WIDTH*VREG_WIDTH-1:0] rat_vrd,
    output logic [WALK_WIDTH*PREG_WIDTH-1:0] rat_prd,
    output logic [WALK_WIDTH-1:0]            fl_free_en,
    output logic [WALK_WIDTH*PREG_WIDTH-1:0] fl_free_prd,
    output logic                             busy,
    output logic                             done
);

    // Handshake: a request transfers when rd_valid & rd_ready at a rising edge;
    // its response is on ent_* in the following cycle only.
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN} state_t;

    state_t                 state, state_d;
    logic [ROB_WIDTH-1:0]   cur_idx, cur_idx_d;
    logic [CNT_WIDTH-1:0]   remaining, remaining_d;
    logic                   resp_valid, resp_valid_d;
    logic [WALK_WIDTH-1:0]  resp_mask, resp_mask_d;
    logic                   done_zero, done_zero_d;
    logic [CNT_WIDTH-1:0]   grp_cnt;
    logic [WALK_WIDTH-1:0]  grp_mask;
    logic                   fire;
    logic                   resp_ok;
    logic [WALK_WIDTH-1:0]  lane_we;
    logic [WALK_WIDTH-1:0]  lane_kill;

    always_comb begin
        grp_cnt = (remaining > CNT_WIDTH'(WALK_WIDTH)) ? CNT_WIDTH'(WALK_WIDTH) : remaining;
        grp_mask = '0;
        for (int i = 0; i < WALK_WIDTH; i++) begin
            grp_mask[i] = (CNT_WIDTH'(i) < grp_cnt);
        end
    end

    assign fire = (state == S_WALK) && rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_idx    <= '0;
            remaining  <= '0;
            resp_valid <= 1'b0;
            resp_mask  <= '0;
            done_zero  <= 1'b0;
        end else begin
            state      <= state_d;
            cur_idx    <= cur_idx_d;
            remaining  <= remaining_d;
            resp_valid <= resp_valid_d;
            resp_mask  <= resp_mask_d;
            done_zero  <= done_zero_d;
        end
    end

    always_comb begin
        state_d      = state;
        cur_idx_d    = cur_idx;
        remaining_d  = remaining;
        resp_valid_d = fire;
        resp_mask_d  = fire ? grp_mask : '0;
        done_zero_d  = 1'b0;
        case (state)
            S_WALK: begin
                if (fire) begin
                    cur_idx_d   = cur_idx - ROB_WIDTH'(grp_cnt);
                    remaining_d = remaining - grp_cnt;
                    if (remaining_d == '0) state_d = S_DRAIN;
                end
            end
            // DRAIN is only entered on an accepted request, so its response is present.
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A restart wins over everything, including the response of this cycle's request.
        if (walk_start) begin
            cur_idx_d    = walk_tail;
            remaining_d  = walk_num;
            resp_valid_d = 1'b0;
            resp_mask_d  = '0;
            if (walk_num != '0) begin
                state_d = S_WALK;
            end else begin
                state_d     = S_IDLE;
                done_zero_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid    = (state == S_WALK);
        rd_idx      = (state == S_WALK) ? cur_idx : '0;
        rd_mask     = (state == S_WALK) ? grp_mask : '0;
        busy        = (state != S_IDLE);
        resp_ok     = resp_valid && !walk_start;
        done        = done_zero || ((state == S_DRAIN) && resp_ok);
        lane_we     = '0;
        lane_kill   = '0;
        rat_vrd     = '0;
        rat_prd     = '0;
        fl_free_prd = '0;
        for (int i = 0; i < WALK_WIDTH; i++) begin
            lane_we[i] = resp_ok && resp_mask[i] && ent_we[i];
        end
        // Higher lanes are older; the oldest writer of a vrd holds the true prior mapping.
        for (int i = 0; i < WALK_WIDTH; i++) begin
            for (int j = i + 1; j < WALK_WIDTH; j++) begin
                if (lane_we[j] && (ent_vrd[j*VREG_WIDTH +: VREG_WIDTH] == ent_vrd[i*VREG_WIDTH +: VREG_WIDTH]))
                    lane_kill[i] = 1'b1;
            end
        end
        if (resp_ok) begin
            rat_vrd     = ent_vrd;
            rat_prd     = ent_old_prd;
            fl_free_prd = ent_prd;
        end
        fl_free_en = lane_we;
        rat_we     = lane_we & ~lane_kill;
    end

endmodule

// File: tb/tb_rename_walk.sv
// Directed bench for rename_walk: table of single-group responses plus
// hand-written multi-cycle sequences (split groups, stall, restart, reset).
module tb_rename_walk;

    logic        clk = 1'b0;
    logic        rst;
    logic        walk_start;
    logic [5:0]  walk_tail;
    logic [6:0]  walk_num;
    logic        rd_valid;
    logic [5:0]  rd_idx;
    logic [3:0]  rd_mask;
    logic        rd_ready;
    logic [3:0]  ent_we;
    logic [19:0] ent_vrd;
    logic [27:0] ent_prd;
    logic [27:0] ent_old_prd;
    logic [3:0]  rat_we;
    logic [19:0] rat_vrd;
    logic [27:0] rat_prd;
    logic [3:0]  fl_free_en;
    logic [27:0] fl_free_prd;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rename_walk dut (
        .clk(clk), .rst(rst), .walk_start(walk_start), .walk_tail(walk_tail),
        .walk_num(walk_num), .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_mask(rd_mask),
        .rd_ready(rd_ready), .ent_we(ent_we), .ent_vrd(ent_vrd), .ent_prd(ent_prd),
        .ent_old_prd(ent_old_prd), .rat_we(rat_we), .rat_vrd(rat_vrd), .rat_prd(rat_prd),
        .fl_free_en(fl_free_en), .fl_free_prd(fl_free_prd), .busy(busy), .done(done)
    );

    typedef struct {
        logic [5:0]  tail;
        logic [3:0]  we;
        logic [19:0] vrd;
        logic [27:0] prd;
        logic [27:0] old;
        logic [3:0]  exp_rat_we;
        logic [3:0]  exp_fl_en;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [5:0] tail, input logic [6:0] num);
        walk_start = 1'b1;
        walk_tail  = tail;
        walk_num   = num;
    endtask

    initial begin
        rst = 1'b1; walk_start = 1'b0; walk_tail = '0; walk_num = '0; rd_ready = 1'b0;
        ent_we = '0; ent_vrd = '0; ent_prd = '0; ent_old_prd = '0;

        // lanes listed {3,2,1,0}
        vecs[0] = '{6'd1,  4'b0101, {5'd2,5'd5,5'd1,5'd5}, {7'd13,7'd12,7'd11,7'd10}, {7'd43,7'd33,7'd41,7'd40}, 4'b0100, 4'b0101};
        vecs[1] = '{6'd0,  4'b1111, {5'd4,5'd3,5'd2,5'd1}, {7'd23,7'd22,7'd21,7'd20}, {7'd53,7'd52,7'd51,7'd50}, 4'b1111, 4'b1111};
        vecs[2] = '{6'd63, 4'b1111, {5'd7,5'd7,5'd7,5'd7}, {7'd33,7'd32,7'd31,7'd30}, {7'd63,7'd62,7'd61,7'd60}, 4'b1000, 4'b1111};
        vecs[3] = '{6'd30, 4'b0000, {5'd1,5'd1,5'd1,5'd1}, {7'd3,7'd2,7'd1,7'd0},     {7'd7,7'd6,7'd5,7'd4},     4'b0000, 4'b0000};
        vecs[4] = '{6'd17, 4'b1011, {5'd3,5'd9,5'd3,5'd3}, {7'd90,7'd91,7'd92,7'd93}, {7'd70,7'd71,7'd72,7'd73}, 4'b1000, 4'b1011};
        vecs[5] = '{6'd5,  4'b0111, {5'd8,5'd8,5'd6,5'd6}, {7'd100,7'd101,7'd102,7'd103}, {7'd1,7'd2,7'd3,7'd4}, 4'b0110, 4'b0111};
        vecs[6] = '{6'd2,  4'b1110, {5'd0,5'd4,5'd4,5'd2}, {7'd110,7'd111,7'd112,7'd113}, {7'd9,7'd8,7'd7,7'd6}, 4'b1100, 4'b1110};

        // reset values
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_mask", rd_mask, 0);
        chk("rst_rd_idx", rd_idx, 0);
        chk("rst_rat_we", rat_we, 0);
        chk("rst_fl_en", fl_free_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rat_prd", rat_prd, 0);
        chk("rst_fl_prd", fl_free_prd, 0);
        step();
        rst = 1'b0;
        step();

        // single-group response table, ent_* driven early to show they are ignored until valid
        for (int i = 0; i < 7; i++) begin
            start(vecs[i].tail, 7'd4);
            rd_ready = 1'b1;
            ent_we = vecs[i].we; ent_vrd = vecs[i].vrd; ent_prd = vecs[i].prd; ent_old_prd = vecs[i].old;
            @(negedge clk);
            chk("v_start_rat_we", rat_we, 0);
            chk("v_start_fl_en", fl_free_en, 0);
            step();
            walk_start = 1'b0;
            @(negedge clk);
            chk("v_rd_valid", rd_valid, 1);
            chk("v_rd_idx", rd_idx, vecs[i].tail);
            chk("v_rd_mask", rd_mask, 4'b1111);
            chk("v_req_fl_en", fl_free_en, 0);
            step();
            @(negedge clk);
            chk("v_rat_we", rat_we, vecs[i].exp_rat_we);
            chk("v_fl_en", fl_free_en, vecs[i].exp_fl_en);
            chk("v_rat_vrd", rat_vrd, vecs[i].vrd);
            chk("v_rat_prd", rat_prd, vecs[i].old);
            chk("v_fl_prd", fl_free_prd, vecs[i].prd);
            chk("v_done", done, 1);
            chk("v_drain_rd_valid", rd_valid, 0);
            step();
            @(negedge clk);
            chk("v_idle_busy", busy, 0);
            chk("v_idle_done", done, 0);
            chk("v_idle_fl_en", fl_free_en, 0);
            step();
        end

        // two groups: tail 10, 6 entries
        ent_we = 4'b0000;
        start(6'd10, 7'd6);
        step();
        walk_start = 1'b0;
        @(negedge clk);
        chk("a_idx0", rd_idx, 10);
        chk("a_mask0", rd_mask, 4'b1111);
        chk("a_busy", busy, 1);
        step();
        @(negedge clk);
        chk("a_idx1", rd_idx, 6);
        chk("a_mask1", rd_mask, 4'b0011);
        chk("a_done_early", done, 0);
        step();
        @(negedge clk);
        chk("a_done", done, 1);
        chk("a_rd_valid", rd_valid, 0);
        step();
        @(negedge clk);
        chk("a_done_once", done, 0);
        chk("a_busy_end", busy, 0);
        step();

        // stall three cycles, tail 2 wraps to 62
        ent_we = 4'b1111;
        rd_ready = 1'b0;
        start(6'd2, 7'd6);
        step();
        walk_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_hold_idx", rd_idx, 2);
            chk("b_hold_mask", rd_mask, 4'b1111);
            chk("b_hold_fl_en", fl_free_en, 0);
            chk("b_hold_done", done, 0);
            step();
        end
        rd_ready = 1'b1;
        @(negedge clk);
        chk("b_idx0", rd_idx, 2);
        step();
        @(negedge clk);
        chk("b_wrap_idx", rd_idx, 62);
        chk("b_wrap_mask", rd_mask, 4'b0011);
        chk("b_fl_en0", fl_free_en, 4'b1111);
        chk("b_done_early", done, 0);
        step();
        @(negedge clk);
        chk("b_fl_en1", fl_free_en, 4'b0011);
        chk("b_done", done, 1);
        step();

        // restart while a response is pending
        start(6'd40, 7'd8);
        step();
        walk_start = 1'b0;
        @(negedge clk);
        chk("c_idx0", rd_idx, 40);
        step();
        start(6'd20, 7'd2);
        @(negedge clk);
        chk("c_start_fl_en", fl_free_en, 0);
        chk("c_start_rat_we", rat_we, 0);
        chk("c_start_done", done, 0);
        step();
        walk_start = 1'b0;
        @(negedge clk);
        chk("c_discard_fl_en", fl_free_en, 0);
        chk("c_idx", rd_idx, 20);
        chk("c_mask", rd_mask, 4'b0011);
        step();
        @(negedge clk);
        chk("c_fl_en", fl_free_en, 4'b0011);
        chk("c_done", done, 1);
        step();
        @(negedge clk);
        chk("c_busy_end", busy, 0);
        step();

        // zero-length walk
        start(6'd9, 7'd0);
        @(negedge clk);
        chk("d_busy0", busy, 0);
        step();
        walk_start = 1'b0;
        @(negedge clk);
        chk("d_done", done, 1);
        chk("d_busy", busy, 0);
        chk("d_rd_valid", rd_valid, 0);
        step();
        @(negedge clk);
        chk("d_done_once", done, 0);
        chk("d_rd_valid2", rd_valid, 0);
        step();

        // reset during a response cycle
        start(6'd10, 7'd8);
        step();
        walk_start = 1'b0;
        step();
        @(negedge clk);
        chk("e_fl_en_live", fl_free_en, 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("e_rst_fl_en", fl_free_en, 0);
        chk("e_rst_rat_we", rat_we, 0);
        chk("e_rst_rd_valid", rd_valid, 0);
        chk("e_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("e_post_rd_valid", rd_valid, 0);
            chk("e_post_fl_en", fl_free_en, 0);
            chk("e_post_done", done, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
